// File: rtl/frame_capture_ctrl_if.sv
// Bundles the pixel stream, capture control/status and BRAM write port of frame_capture_ctrl.
// The 'continuous' signal exists only when FRAME_CAPTURE_CONT_EN is defined.
interface frame_capture_ctrl_if #(
  parameter int WIDTH_COLOR = 4,
  parameter int WIDTH_ADDR  = 16
) ();
  logic                   write_next_frame;
  logic                   pix_valid;
  logic [WIDTH_COLOR-1:0] pix_data;
  logic                   href;
  logic                   vsync;
`ifdef FRAME_CAPTURE_CONT_EN
  logic                   continuous;
`endif
  logic                   busy;
  logic                   done;
  logic                   short_frame;
  logic                   ena;
  logic                   wea;
  logic [WIDTH_ADDR-1:0]  address;
  logic [WIDTH_COLOR-1:0] color_write;

  modport slave (
    input  write_next_frame, pix_valid, pix_data, href, vsync,
`ifdef FRAME_CAPTURE_CONT_EN
    input  continuous,
`endif
    output busy, done, short_frame, ena, wea, address, color_write
  );

  modport master (
    output write_next_frame, pix_valid, pix_data, href, vsync,
`ifdef FRAME_CAPTURE_CONT_EN
    output continuous,
`endif
    input  busy, done, short_frame, ena, wea, address, color_write
  );
endinterface

// File: rtl/frame_capture_ctrl.sv
// Camera-to-BRAM frame grabber: windows and decimates one gray frame per request into the image BRAM.
// Optional FRAME_CAPTURE_CONT_EN adds a 'continuous' input that re-arms after each frame.
module frame_capture_ctrl #(
  parameter int WIDTH_COLOR = 4,
  parameter int WIDTH_ADDR  = 16,
  parameter int WIDTH_IMG   = 200,
  parameter int HEIGHT_IMG  = 200,
  parameter int X_OFFSET    = 0,
  parameter int Y_OFFSET    = 0,
  parameter int DECIM_X     = 2,
  parameter int DECIM_Y     = 2
) (
  input logic                  pixel_clk,
  input logic                  rst,
  frame_capture_ctrl_if.slave  bus
);

  localparam int XW  = $clog2(X_OFFSET + 2);
  localparam int YW  = $clog2(Y_OFFSET + 2);
  localparam int PXW = $clog2(DECIM_X + 1);
  localparam int PYW = $clog2(DECIM_Y + 1);
  localparam int CW  = $clog2(WIDTH_IMG + 1);
  localparam int RW  = $clog2(HEIGHT_IMG + 1);

  localparam logic [XW-1:0]         XOFF     = XW'(X_OFFSET);
  localparam logic [YW-1:0]         YOFF     = YW'(Y_OFFSET);
  localparam logic [PXW-1:0]        PX_LAST  = PXW'(DECIM_X - 1);
  localparam logic [PYW-1:0]        PY_LAST  = PYW'(DECIM_Y - 1);
  localparam logic [CW-1:0]         COL_MAX  = CW'(WIDTH_IMG);
  localparam logic [CW-1:0]         COL_LAST = CW'(WIDTH_IMG - 1);
  localparam logic [RW-1:0]         ROW_MAX  = RW'(HEIGHT_IMG);
  localparam logic [RW-1:0]         ROW_LAST = RW'(HEIGHT_IMG - 1);
  localparam logic [WIDTH_ADDR-1:0] ROW_STEP = WIDTH_ADDR'(WIDTH_IMG);

  typedef enum logic [1:0] {S_IDLE, S_ARMED, S_CAPTURE, S_DONE} state_t;

  state_t                 state_q, state_d;
  logic                   href_q, vsync_q;
  logic [XW-1:0]          xcnt_q, xcnt_d;
  logic [PXW-1:0]         xph_q, xph_d;
  logic [CW-1:0]          col_q, col_d;
  logic [YW-1:0]          ycnt_q, ycnt_d;
  logic [PYW-1:0]         yph_q, yph_d;
  logic [RW-1:0]          row_q, row_d;
  logic [WIDTH_ADDR-1:0]  row_base_q, row_base_d;
  logic                   last_wr_q, last_wr_d;
  logic                   short_q, short_d;
  logic                   ena_q, ena_d;
  logic [WIDTH_ADDR-1:0]  addr_q, addr_d;
  logic [WIDTH_COLOR-1:0] color_q, color_d;

  logic           href_rise, href_fall, vsync_rise, cont;
  logic [XW-1:0]  x_cnt;
  logic [PXW-1:0] x_ph;
  logic [CW-1:0]  col_eff;
  logic           pix_in, x_in, y_in, store, store_last;

`ifdef FRAME_CAPTURE_CONT_EN
  assign cont = bus.continuous;
`else
  assign cont = 1'b0;
`endif

  assign href_rise  = bus.href & ~href_q;
  assign href_fall  = ~bus.href & href_q;
  assign vsync_rise = bus.vsync & ~vsync_q;

  // Horizontal counters read as zero on the href-rise cycle so that cycle's pixel is src_x 0.
  assign x_cnt   = href_rise ? '0 : xcnt_q;
  assign x_ph    = href_rise ? '0 : xph_q;
  assign col_eff = href_rise ? '0 : col_q;

  assign pix_in     = (state_q == S_CAPTURE) && bus.pix_valid && bus.href;
  assign x_in       = (x_cnt == XOFF);
  assign y_in       = (ycnt_q == YOFF);
  assign store      = pix_in && x_in && (x_ph == '0) && (col_eff < COL_MAX)
                      && y_in && (yph_q == '0) && (row_q < ROW_MAX);
  assign store_last = store && (row_q == ROW_LAST) && (col_eff == COL_LAST);

  always_comb begin
    state_d    = state_q;
    xcnt_d     = x_cnt;
    xph_d      = x_ph;
    col_d      = col_eff;
    ycnt_d     = ycnt_q;
    yph_d      = yph_q;
    row_d      = row_q;
    row_base_d = row_base_q;
    last_wr_d  = 1'b0;
    short_d    = short_q;
    ena_d      = 1'b0;
    addr_d     = addr_q;
    color_d    = color_q;

    // Offset counters saturate at the offset; past it the phase counters do the decimation.
    if (pix_in) begin
      if (!x_in) begin
        xcnt_d = x_cnt + 1'b1;
      end else begin
        xph_d = (x_ph == PX_LAST) ? '0 : x_ph + 1'b1;
        if ((x_ph == '0) && (col_eff < COL_MAX)) col_d = col_eff + 1'b1;
      end
    end

    if ((state_q == S_CAPTURE) && href_fall) begin
      if (!y_in) begin
        ycnt_d = ycnt_q + 1'b1;
      end else begin
        yph_d = (yph_q == PY_LAST) ? '0 : yph_q + 1'b1;
        if ((yph_q == '0) && (row_q < ROW_MAX)) begin
          row_d      = row_q + 1'b1;
          row_base_d = row_base_q + ROW_STEP;
        end
      end
    end

    if (store) begin
      ena_d     = 1'b1;
      addr_d    = row_base_q + WIDTH_ADDR'(col_eff);
      color_d   = bus.pix_data;
      last_wr_d = store_last;
    end

    unique case (state_q)
      S_IDLE: begin
        if (bus.write_next_frame) begin
          state_d = S_ARMED;
          short_d = 1'b0;
        end
      end
      S_ARMED: begin
        if (vsync_rise) begin
          state_d    = S_CAPTURE;
          xcnt_d     = '0;
          xph_d      = '0;
          col_d      = '0;
          ycnt_d     = '0;
          yph_d      = '0;
          row_d      = '0;
          row_base_d = '0;
        end
      end
      S_CAPTURE: begin
        // A vsync rise coinciding with the final pixel still lets that frame finish complete.
        if (last_wr_q) begin
          state_d = S_DONE;
          short_d = 1'b0;
        end else if (vsync_rise && !store_last) begin
          state_d = S_DONE;
          short_d = 1'b1;
        end
      end
      S_DONE: begin
        if (cont) begin
          state_d = S_ARMED;
          short_d = 1'b0;
        end else begin
          state_d = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  always_ff @(posedge pixel_clk) begin
    if (rst) begin
      state_q    <= S_IDLE;
      href_q     <= 1'b0;
      vsync_q    <= 1'b0;
      xcnt_q     <= '0;
      xph_q      <= '0;
      col_q      <= '0;
      ycnt_q     <= '0;
      yph_q      <= '0;
      row_q      <= '0;
      row_base_q <= '0;
      last_wr_q  <= 1'b0;
      short_q    <= 1'b0;
      ena_q      <= 1'b0;
      addr_q     <= '0;
      color_q    <= '0;
    end else begin
      state_q    <= state_d;
      href_q     <= bus.href;
      vsync_q    <= bus.vsync;
      xcnt_q     <= xcnt_d;
      xph_q      <= xph_d;
      col_q      <= col_d;
      ycnt_q     <= ycnt_d;
      yph_q      <= yph_d;
      row_q      <= row_d;
      row_base_q <= row_base_d;
      last_wr_q  <= last_wr_d;
      short_q    <= short_d;
      ena_q      <= ena_d;
      addr_q     <= addr_d;
      color_q    <= color_d;
    end
  end

  assign bus.busy        = (state_q == S_ARMED) || (state_q == S_CAPTURE);
  assign bus.done        = (state_q == S_DONE);
  assign bus.short_frame = short_q;
  assign bus.ena         = ena_q;
  assign bus.wea         = ena_q;
  assign bus.address     = addr_q;
  assign bus.color_write = color_q;

endmodule

// File: tb/tb_frame_capture_ctrl.sv
// Scoreboard bench for frame_capture_ctrl: a frame-level reference model queues expected BRAM
// writes and done pulses; a negedge monitor compares them as the DUT presents them.
module tb_frame_capture_ctrl;
  localparam int WC = 4, WA = 16, W = 4, H = 3, XO = 1, YO = 1, DX = 2, DY = 2;

  logic clk = 1'b0;
  logic rst;
  always #5 clk = ~clk;

  frame_capture_ctrl_if #(.WIDTH_COLOR(WC), .WIDTH_ADDR(WA)) bus ();

  frame_capture_ctrl #(
    .WIDTH_COLOR(WC), .WIDTH_ADDR(WA), .WIDTH_IMG(W), .HEIGHT_IMG(H),
    .X_OFFSET(XO), .Y_OFFSET(YO), .DECIM_X(DX), .DECIM_Y(DY)
  ) dut (
    .pixel_clk(clk),
    .rst      (rst),
    .bus      (bus)
  );

  typedef struct {
    bit is_done;
    int addr;
    int data;
    bit shrt;
  } ev_t;

  ev_t exp_q[$];
  int  errors = 0, checks = 0, wr_cnt = 0, done_cnt = 0;
  bit  cap_on = 1'b0, armed = 1'b0;
  int  line = 0;

  function automatic void check(string name, int act, int expv);
    checks++;
    if (act != expv) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", name, act, expv);
    end
  endfunction

  function automatic bit cont_now();
`ifdef FRAME_CAPTURE_CONT_EN
    return bus.continuous;
`else
    return 1'b0;
`endif
  endfunction

  function automatic void push_write(int a, int d);
    ev_t e;
    e.is_done = 1'b0; e.addr = a; e.data = d; e.shrt = 1'b0;
    exp_q.push_back(e);
  endfunction

  function automatic void push_done(bit s);
    ev_t e;
    e.is_done = 1'b1; e.addr = 0; e.data = 0; e.shrt = s;
    exp_q.push_back(e);
  endfunction

  // Frame-level model: which source pixel lands where, and when the frame ends.
  function automatic void model_vsync_rise();
    if (cap_on) begin
      push_done(1'b1);
      cap_on = 1'b0;
      armed  = cont_now() || bus.write_next_frame;
    end else if (armed) begin
      cap_on = 1'b1;
      armed  = 1'b0;
      line   = 0;
    end
  endfunction

  function automatic void model_pixel(int x, int d);
    int r, c;
    if (cap_on && line >= YO && (line - YO) % DY == 0 && x >= XO && (x - XO) % DX == 0) begin
      r = (line - YO) / DY;
      c = (x - XO) / DX;
      if (r < H && c < W) begin
        push_write(r * W + c, d);
        if (r == H - 1 && c == W - 1) begin
          push_done(1'b0);
          cap_on = 1'b0;
          armed  = cont_now() || bus.write_next_frame;
        end
      end
    end
  endfunction

  always @(negedge clk) begin
    ev_t e;
    if (bus.ena) begin
      wr_cnt++;
      check("write_expected", int'(exp_q.size() > 0 && !exp_q[0].is_done), 1);
      check("wea_with_ena", int'(bus.wea), 1);
      if (exp_q.size() > 0 && !exp_q[0].is_done) begin
        e = exp_q.pop_front();
        check("write_addr", int'(bus.address), e.addr);
        check("write_data", int'(bus.color_write), e.data);
      end
    end
    if (bus.done) begin
      done_cnt++;
      check("done_expected", int'(exp_q.size() > 0 && exp_q[0].is_done), 1);
      check("busy_in_done", int'(bus.busy), 0);
      if (exp_q.size() > 0 && exp_q[0].is_done) begin
        e = exp_q.pop_front();
        check("short_frame", int'(bus.short_frame), int'(e.shrt));
      end
    end
  end

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic request();
    bus.write_next_frame = 1'b1;
    if (!cap_on) armed = 1'b1;
    step();
    bus.write_next_frame = 1'b0;
  endtask

  task automatic vsync_pulse();
    bus.vsync = 1'b1;
    model_vsync_rise();
    step();
    step();
    bus.vsync = 1'b0;
    repeat (3) step();
  endtask

  task automatic drive_px(int x, int d, bit vs);
    bit was;
    was = cap_on;
    bus.pix_valid = 1'b1;
    bus.pix_data  = WC'(d);
    if (vs) bus.vsync = 1'b1;
    model_pixel(x, d);
    if (vs && (cap_on || !was)) model_vsync_rise();
    step();
  endtask

  task automatic send_line(int npix, bit fixed, bit vs_last);
    int x, d;
    x = 0;
    bus.href = 1'b1;
    while (x < npix) begin
      if (!fixed && $urandom_range(0, 3) == 0) begin
        bus.pix_valid = 1'b0;
        step();
      end else begin
        d = fixed ? x % 16 : int'($urandom_range(0, 15));
        drive_px(x, d, vs_last && x == npix - 1);
        x++;
      end
    end
    bus.href = 1'b0;
    bus.vsync = 1'b0;
    for (int i = 0; i < 3; i++) begin
      bus.pix_valid = 1'($urandom_range(0, 1));
      bus.pix_data  = WC'($urandom_range(0, 15));
      step();
    end
    bus.pix_valid = 1'b0;
    if (cap_on) line++;
  endtask

  task automatic wait_drain(string name);
    int n;
    n = 0;
    while (exp_q.size() != 0 && n < 200) begin
      step();
      n++;
    end
    check({"drain_", name}, exp_q.size(), 0);
  endtask

  int w0, d0;

  initial begin
    bus.write_next_frame = 1'b0;
    bus.pix_valid = 1'b0;
    bus.pix_data  = '0;
    bus.href      = 1'b0;
    bus.vsync     = 1'b0;
`ifdef FRAME_CAPTURE_CONT_EN
    bus.continuous = 1'b0;
`endif
    rst = 1'b1;
    repeat (3) step();
    check("rst_busy", int'(bus.busy), 0);
    check("rst_done", int'(bus.done), 0);
    check("rst_short", int'(bus.short_frame), 0);
    check("rst_ena", int'(bus.ena), 0);
    check("rst_wea", int'(bus.wea), 0);
    check("rst_address", int'(bus.address), 0);
    check("rst_color", int'(bus.color_write), 0);
    rst = 1'b0;
    step();

    // Full frame, pix_data = src_x.
    w0 = wr_cnt; d0 = done_cnt;
    request();
    check("t1_busy_armed", int'(bus.busy), 1);
    vsync_pulse();
    for (int i = 0; i < 8; i++) send_line(10, 1'b1, 1'b0);
    vsync_pulse();
    wait_drain("t1");
    check("t1_writes", wr_cnt - w0, 12);
    check("t1_dones", done_cnt - d0, 1);
    check("t1_idle", int'(bus.busy), 0);

    // No request: nothing may be written.
    w0 = wr_cnt; d0 = done_cnt;
    vsync_pulse();
    for (int i = 0; i < 8; i++) send_line(10, 1'b1, 1'b0);
    vsync_pulse();
    check("t2_writes", wr_cnt - w0, 0);
    check("t2_dones", done_cnt - d0, 0);
    check("t2_busy", int'(bus.busy), 0);

    // Short frame.
    w0 = wr_cnt;
    request();
    vsync_pulse();
    send_line(4, 1'b1, 1'b0);
    send_line(4, 1'b1, 1'b0);
    vsync_pulse();
    wait_drain("t3");
    check("t3_writes", wr_cnt - w0, 2);
    repeat (4) step();
    check("t3_short_hold", int'(bus.short_frame), 1);
    request();
    check("t3_short_clear", int'(bus.short_frame), 0);
    check("t3_busy_armed", int'(bus.busy), 1);

    // Reset in the middle of row 1, together with a storable pixel.
    d0 = done_cnt;
    vsync_pulse();
    send_line(4, 1'b1, 1'b0);
    bus.href = 1'b1;
    drive_px(0, 0, 1'b0);
    drive_px(1, 1, 1'b0);
    bus.pix_valid = 1'b0;
    repeat (3) step();
    wait_drain("t4");
    drive_px(2, 2, 1'b0);
    bus.pix_valid = 1'b1;
    bus.pix_data  = WC'(3);
    rst = 1'b1;
    step();
    check("t4_busy", int'(bus.busy), 0);
    check("t4_ena", int'(bus.ena), 0);
    check("t4_wea", int'(bus.wea), 0);
    check("t4_address", int'(bus.address), 0);
    rst = 1'b0;
    bus.pix_valid = 1'b0;
    bus.href = 1'b0;
    cap_on = 1'b0; armed = 1'b0; line = 0;
    repeat (5) step();
    check("t4_no_done", done_cnt - d0, 0);

    // Request held through the capture: one frame, then re-armed via IDLE.
    w0 = wr_cnt; d0 = done_cnt;
    bus.write_next_frame = 1'b1;
    armed = 1'b1;
    step();
    vsync_pulse();
    for (int i = 0; i < 8; i++) send_line(10, 1'b1, 1'b0);
    wait_drain("t5");
    check("t5_writes", wr_cnt - w0, 12);
    check("t5_dones", done_cnt - d0, 1);
    check("t5_rearmed", int'(bus.busy), 1);
    bus.write_next_frame = 1'b0;
    rst = 1'b1;
    step();
    rst = 1'b0;
    armed = 1'b0;
    step();

    // Last pixel coincides with the vsync rise: the frame completes, not short.
    request();
    vsync_pulse();
    for (int i = 0; i < 5; i++) send_line(9, 1'b1, 1'b0);
    send_line(8, 1'b1, 1'b1);
    wait_drain("vs_last");
    repeat (2) step();
    check("vs_last_short", int'(bus.short_frame), 0);

`ifdef FRAME_CAPTURE_CONT_EN
    w0 = wr_cnt; d0 = done_cnt;
    bus.continuous = 1'b1;
    request();
    vsync_pulse();
    for (int i = 0; i < 6; i++) send_line(10, 1'b1, 1'b0);
    bus.continuous = 1'b0;
    vsync_pulse();
    for (int i = 0; i < 6; i++) send_line(10, 1'b1, 1'b0);
    wait_drain("t6");
    check("t6_writes", wr_cnt - w0, 24);
    check("t6_dones", done_cnt - d0, 2);
`endif

    // Randomised frames of varying length and line width.
    for (int f = 0; f < 14; f++) begin
      int nl;
      if ($urandom_range(0, 3) != 0 && !cap_on) request();
      vsync_pulse();
      nl = $urandom_range(2, 8);
      for (int l = 0; l < nl; l++)
        send_line($urandom_range(3, 10), 1'b0, (l == nl - 1) && ($urandom_range(0, 3) == 0));
    end
    vsync_pulse();
    wait_drain("random");

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1);
  end

endmodule
